// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: serial format selection and
// the two-state run/idle encoding.
package i2s_pkg;

  localparam logic I2S_MODE_PHILIPS = 1'b0;
  localparam logic I2S_MODE_LJ      = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Show-ahead synchronous FIFO holding packed {left, right} sample pairs.
// rdata always presents the oldest entry, so it can be consumed in the pop cycle.
module i2s_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign level   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_stream.sv
// I2S master transmitter: buffers stereo pairs, divides clk into sck and
// shifts each frame out MSB first in Philips or left-justified format.
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 16,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_left,
  input  logic [DATA_W-1:0]             in_right,
  output logic                          sck,
  output logic                          ws,
  output logic                          sd,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                  state_reg, state_next;
  logic [DIV_W-1:0]        div_cnt_reg;
  logic [BW-1:0]           bit_cnt_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0]   load_word;
  logic [SLOT_W-1:0]       left_slot, right_slot;
  logic                    sck_reg, ws_reg, sd_reg, mode_reg;
  logic                    frame_done_reg, underrun_reg;
  logic                    div_wrap, last_bit;
  logic                    entry, fall, load, fifo_pop;
  logic                    fifo_full, fifo_empty;
  logic [2*DATA_W-1:0]     fifo_rdata;

  i2s_frame_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .wdata ({in_left, in_right}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready   = !fifo_full;
  assign sck        = sck_reg;
  assign ws         = ws_reg;
  assign sd         = sd_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;
  assign div_wrap   = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign last_bit   = (bit_cnt_reg == BW'(FRAME_BITS - 1));

  // Samples sit MSB-aligned in their slot; an empty FIFO yields a silent frame.
  always_comb begin
    left_slot  = '0;
    right_slot = '0;
    left_slot[SLOT_W-1 -: DATA_W]  = fifo_rdata[2*DATA_W-1 -: DATA_W];
    right_slot[SLOT_W-1 -: DATA_W] = fifo_rdata[DATA_W-1:0];
    load_word = fifo_empty ? '0 : {left_slot, right_slot};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable)  state_next = ST_RUN;
      ST_RUN:  if (!enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    entry = 1'b0;
    fall  = 1'b0;
    case (state_reg)
      ST_IDLE: entry = enable;
      ST_RUN:  fall  = enable && div_wrap && sck_reg;
      default: ;
    endcase
    load     = entry || (fall && last_bit);
    fifo_pop = load && !fifo_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      sck_reg        <= 1'b0;
      ws_reg         <= 1'b0;
      sd_reg         <= 1'b0;
      mode_reg       <= I2S_MODE_PHILIPS;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (!enable)                  underrun_reg <= 1'b0;
      else if (load && fifo_empty)  underrun_reg <= 1'b1;

      if (state_reg == ST_RUN && enable) begin
        if (div_wrap) begin
          div_cnt_reg <= '0;
          sck_reg     <= !sck_reg;
        end else begin
          div_cnt_reg <= div_cnt_reg + 1'b1;
        end
        // Philips re-times the bit that just finished; LJ shows the new MSB.
        if (fall) begin
          if (last_bit) begin
            shift_reg      <= load_word;
            bit_cnt_reg    <= '0;
            ws_reg         <= 1'b0;
            frame_done_reg <= 1'b1;
            sd_reg <= (mode_reg == I2S_MODE_LJ) ? load_word[FRAME_BITS-1]
                                                : shift_reg[FRAME_BITS-1];
          end else begin
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            ws_reg      <= (bit_cnt_reg >= BW'(SLOT_W - 1));
            sd_reg <= (mode_reg == I2S_MODE_LJ) ? shift_reg[FRAME_BITS-2]
                                                : shift_reg[FRAME_BITS-1];
          end
        end
      end else if (entry) begin
        mode_reg    <= mode;
        shift_reg   <= load_word;
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        sck_reg     <= 1'b0;
        ws_reg      <= 1'b0;
        sd_reg      <= (mode == I2S_MODE_LJ) ? load_word[FRAME_BITS-1] : 1'b0;
      end else begin
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        sck_reg     <= 1'b0;
        ws_reg      <= 1'b0;
        sd_reg      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2s_tx_stream.md
Name: i2s_tx_stream

Overview:
Parametrised next-generation I2S master transmitter.
- Accepts stereo sample pairs over a valid/ready stream into an internal frame FIFO.
- Generates the serial bit clock, word select and serial data, with a configurable sample width, slot width and bit-clock divider.
- Supports Philips I2S and left-justified modes.
- Reports underrun and frame completion; it pairs with the existing I2S slave receiver.

Parameters:
- DATA_W, 16: sample width per channel, in bits.
- SLOT_W, 16: bits per channel slot. SLOT_W >= DATA_W; unused LSBs are sent as 0.
- CLK_DIV, 2: clk cycles per sck half-period, >= 1.
- FIFO_DEPTH, 4: stereo frames buffered. Power of 2, >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  1 = transmit; 0 = stop the serial interface.
- mode  in  1  0 = Philips I2S (1-bit delay), 1 = left-justified. Sampled only on entry to RUN.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  FIFO can accept a pair (= !full).
- in_left  in  DATA_W  left sample.
- in_right  in  DATA_W  right sample.
- sck  out  1  bit clock.
- ws  out  1  word select: 0 = left, 1 = right.
- sd  out  1  serial data, MSB first.
- frame_done  out  1  one-cycle pulse when the last right-slot bit period ends.
- underrun  out  1  sticky; set when a frame starts with the FIFO empty; cleared while enable = 0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.

Behaviour:
- Reset values: sck = 0, ws = 0, sd = 0, in_ready = 1, frame_done = 0, underrun = 0, fifo_level = 0. FIFO is emptied and the FSM goes to IDLE.
- FIFO
  - Push when in_valid && in_ready.
  - Pop at each frame load.
  - Push and pop in the same cycle is allowed when not full, and the level is unchanged.
  - When full, in_ready = 0, so a push is impossible.
  - FIFO contents are independent of enable.
- FSM states:
  - IDLE: sck, ws and sd held at 0; divider and bit counter cleared. Goes to RUN on the first cycle enable = 1.
  - RUN: divider counts 0..CLK_DIV-1, and sck toggles when it wraps.
  - RUN goes to IDLE on the cycle enable = 0. This stops immediately; the partial frame is discarded and is not re-sent.
- Bit timing
  - All ws and sd updates occur on the clk cycle where sck goes 1 to 0 (a "fall event"), plus an initial update on RUN entry.
  - The receiver samples on sck rising.
  - One bit period = 2*CLK_DIV clk cycles.
  - One frame = 2*SLOT_W bit periods.
- Frame load
  - Occurs on RUN entry and on the fall event ending bit index 2*SLOT_W-1.
  - If the FIFO is non-empty: pop, and load the shift register with {left, zeros(SLOT_W-DATA_W), right, zeros(SLOT_W-DATA_W)}.
  - If the FIFO is empty: load all zeros and set underrun.
- ws = 0 for bit indices 0..SLOT_W-1 and 1 for SLOT_W..2*SLOT_W-1.
- Left-justified mode: sd is the current shift-register MSB, so the left MSB coincides with ws falling.
- Philips mode: sd is delayed by one bit period through a 1-bit register.
  - The left MSB appears one bit period after ws falls.
  - The last right bit appears during bit 0 of the following frame.
  - The first bit period after RUN entry outputs sd = 0.
- frame_done pulses on the fall event ending bit 2*SLOT_W-1, i.e. together with the next frame load.
- Reset asserted mid-frame: all outputs return to reset values asynchronously.

Decomposition:
- Package i2s_pkg holds:
  - mode constants I2S_MODE_PHILIPS = 1'b0 and I2S_MODE_LJ = 1'b1;
  - the state encoding ST_IDLE / ST_RUN.
- One sub-module: i2s_frame_fifo, a synchronous FIFO of width 2*DATA_W, parametrised by depth.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Same clk and rstn.
- Serializer, divider and FSM stay in i2s_tx_stream.

Test Plan:
1. Philips mode, defaults, CLK_DIV = 2. Push L = 16'hA5A5, R = 16'h5A5A, then enable.
   - Required: sck period = 4 clk; ws low for 64 clk then high for 64 clk.
   - sd shows the left MSB 1 bit period after ws falls.
   - The slave receiver reports L_DATA = A5A5 and R_DATA = 5A5A.
   - frame_done pulses once per 128 clk.
2. Left-justified mode, same data.
   - Required: the left MSB is on sd in the first bit period after ws falls.
   - The last right bit (0) ends exactly as ws falls again.
3. DATA_W = 16, SLOT_W = 24. Push L = 16'hFFFF.
   - Required: 16 ones, then 8 zeros in the left slot; frame = 192 clk.
4. Underrun: enable with an empty FIFO.
   - Required: sd = 0 for the whole frame and underrun = 1 from the first load.
   - After pushing a pair, data is sent on the next frame.
   - underrun stays 1 until enable = 0.
5. Backpressure, FIFO_DEPTH = 4, hold in_valid = 1.
   - Required: in_ready drops after 4 pushes with fifo_level = 4.
   - It rises for one pair per frame load, with the level returning to 4.
6. Deassert enable at bit 10 of the left slot.
   - Required: next cycle sck = ws = sd = 0.
   - On re-enable, the next FIFO pair is sent from bit 0; the aborted pair is not re-sent.
   - Asserting rstn = 0 mid-frame clears fifo_level to 0 immediately.
